key_expander_seq: RTL and testbench

//  Iterative AES-128 key schedule. Accepts a 128-bit cipher key over a valid/ready

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/key_sched_step.sv | 31 +++
 rtl/key_expander_seq.sv | 100 ++++++++++
 tb/tb_key_expander_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, key-schedule FSM states, rcon helper and the S-box table.
// The S-box lives here so the key schedule and the round datapath share one table.
package aes_pkg;

    localparam int unsigned AES_NR    = 10;
    localparam int unsigned RK_W      = 128;
    localparam logic [7:0]  RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        StIdle,
        StExpand,
        StDone
    } ks_state_e;

    // GF(2^8) multiply by x, reduced by the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Entry 0x00 is the most significant byte
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[(255 - int'(b)) * 8 +: 8];
    endfunction

endpackage

// File: rtl/key_sched_step.sv
// One combinational AES-128 key-schedule step: previous round key plus rcon to next round key.
module key_sched_step
    import aes_pkg::*;
(
    input  logic [RK_W-1:0] prev_key,
    input  logic [7:0]      rcon,
    output logic [RK_W-1:0] next_key
);

    logic [31:0] rot_word;
    logic [31:0] t_word;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;

    assign rot_word = {prev_key[23:0], prev_key[31:24]};

    assign t_word = {sbox(rot_word[31:24]) ^ rcon,
                     sbox(rot_word[23:16]),
                     sbox(rot_word[15:8]),
                     sbox(rot_word[7:0])};

    assign w0 = prev_key[127:96] ^ t_word;
    assign w1 = prev_key[95:64]  ^ w0;
    assign w2 = prev_key[63:32]  ^ w1;
    assign w3 = prev_key[31:0]   ^ w2;

    assign next_key = {w0, w1, w2, w3};

endmodule

// File: rtl/key_expander_seq.sv
// Iterative AES-128 key schedule: accepts a cipher key and writes one round key per clock
// into an 11-entry register file, exposing a read port and the last two round keys.
module key_expander_seq
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = AES_NR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RK_W-1:0] key_in,
    input  logic            key_valid,
    output logic            key_ready,
    output logic            busy,
    output logic            done,
    output logic            keys_valid,
    input  logic [3:0]      rd_idx,
    output logic [RK_W-1:0] rd_key,
    output logic [RK_W-1:0] rk_last_a,
    output logic [RK_W-1:0] rk_last_b
);

    ks_state_e       state_q;
    logic [3:0]      step_q;
    logic [7:0]      rcon_q;
    logic            done_q;
    logic            keys_valid_q;
    logic [RK_W-1:0] rk_q [NUM_ROUNDS+1];

    logic [RK_W-1:0] prev_key;
    logic [RK_W-1:0] next_key;

    // step_q names the entry being written, so the source is the entry just below it
    always_comb begin
        prev_key = '0;
        for (int i = 0; i < NUM_ROUNDS; i++) begin
            if (step_q == 4'(i + 1)) prev_key = rk_q[i];
        end
    end

    key_sched_step u_step (
        .prev_key (prev_key),
        .rcon     (rcon_q),
        .next_key (next_key)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            step_q       <= 4'd0;
            rcon_q       <= RCON_INIT;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (key_valid) begin
                        rk_q[0]      <= key_in;
                        step_q       <= 4'd1;
                        rcon_q       <= RCON_INIT;
                        keys_valid_q <= 1'b0;
                        state_q      <= StExpand;
                    end
                end
                StExpand: begin
                    for (int i = 1; i <= NUM_ROUNDS; i++) begin
                        if (step_q == 4'(i)) rk_q[i] <= next_key;
                    end
                    rcon_q <= xtime(rcon_q);
                    if (step_q == 4'(NUM_ROUNDS)) begin
                        state_q      <= StDone;
                        step_q       <= 4'd0;
                        done_q       <= 1'b1;
                        keys_valid_q <= 1'b1;
                    end else begin
                        step_q <= step_q + 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign key_ready  = (state_q != StExpand);
    assign busy       = (state_q == StExpand);
    assign done       = done_q;
    assign keys_valid = keys_valid_q;
    assign rk_last_a  = rk_q[NUM_ROUNDS-1];
    assign rk_last_b  = rk_q[NUM_ROUNDS];

    // Indices past the last round key read as zero
    always_comb begin
        rd_key = '0;
        for (int i = 0; i <= NUM_ROUNDS; i++) begin
            if (rd_idx == 4'(i)) rd_key = rk_q[i];
        end
    end

endmodule

// File: tb/tb_key_expander_seq.sv
// Self-checking bench for key_expander_seq: known-answer table, corner-case sequences and
// random keys against a word-level key-expansion model with an arithmetically derived S-box.
module tb_key_expander_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic [3:0]   rd_idx = 4'd0;
    logic [127:0] rd_key;
    logic [127:0] rk_last_a;
    logic [127:0] rk_last_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sbox_m [256];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    key_expander_seq dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key),
        .rk_last_a  (rk_last_a),
        .rk_last_b  (rk_last_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                        ^ 8'h63;
        end
    endtask

    // Standard word-oriented expansion into w[0..43]
    function automatic logic [127:0] model_rk(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] temp;
        logic [7:0]  rc;
        rc = 8'h01;
        w[0] = key[127:96];
        w[1] = key[95:64];
        w[2] = key[63:32];
        w[3] = key[31:0];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sbox_m[temp[31:24]], sbox_m[temp[23:16]],
                        sbox_m[temp[15:8]], sbox_m[temp[7:0]]} ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        if (r > 10) return '0;
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input string name, input logic [3:0] idx,
                              input logic [127:0] exp);
        rd_idx = idx;
        #1;
        check(name, rd_key, exp);
    endtask

    // Accept a key, then verify handshake timing through the end of the expansion
    task automatic expand(input logic [127:0] key);
        int cnt;
        int dn;
        cnt = 0;
        while (!key_ready && cnt < 30) begin
            tick();
            cnt++;
        end
        check("ready_before_accept", 128'(key_ready), 128'd1);
        key_in    = key;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        check("busy_after_accept", 128'(busy), 128'd1);
        check("kv_low_after_accept", 128'(keys_valid), 128'd0);
        cnt = 0;
        dn  = 0;
        while (!keys_valid && cnt < 30) begin
            tick();
            cnt++;
            if (done) dn++;
        end
        check("latency", 128'(cnt), 128'd10);
        check("done_pulses", 128'(dn), 128'd1);
        tick();
        check("done_one_cycle", 128'(done), 128'd0);
        check("kv_held", 128'(keys_valid), 128'd1);
    endtask

    typedef struct {
        logic [127:0] key;
        logic [3:0]   idx;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [127:0] cur_key;
        logic [127:0] ka;
        logic [127:0] kb;
        int cnt;
        int dn;

        vecs[0] = '{FIPS_KEY, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[1] = '{FIPS_KEY, 4'd9,  128'hac7766f319fadc2128d12941575c006e};
        vecs[2] = '{FIPS_KEY, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[3] = '{FIPS_KEY, 4'd0,  FIPS_KEY};
        vecs[4] = '{128'h0,   4'd1,  128'h62636363626363636263636362636363};
        vecs[5] = '{128'h0,   4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        vecs[6] = '{128'h0,   4'd11, 128'h0};
        vecs[7] = '{128'h0,   4'd15, 128'h0};

        build_sbox();

        #2;
        check("rst_key_ready", 128'(key_ready), 128'd1);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_keys_valid", 128'(keys_valid), 128'd0);
        check("rst_rk_last_b", rk_last_b, 128'h0);
        tick();
        rst = 1'b0;
        tick();

        // Known-answer table
        cur_key = 128'h1;
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].key !== cur_key) begin
                expand(vecs[v].key);
                cur_key = vecs[v].key;
            end
            read_check($sformatf("vec%0d_rd_key", v), vecs[v].idx, vecs[v].exp);
        end
        for (int i = 12; i < 15; i++) read_check("rd_oob", 4'(i), 128'h0);

        // key_valid during expansion is ignored
        key_in    = FIPS_KEY;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            cnt++;
        end
        key_in    = 128'hdeadbeef_01234567_89abcdef_fedcba98;
        key_valid = 1'b1;
        check("ready_low_expand", 128'(key_ready), 128'd0);
        tick();
        cnt++;
        key_valid = 1'b0;
        while (!keys_valid && cnt < 30) begin
            tick();
            cnt++;
        end
        check("ignore_latency", 128'(cnt), 128'd10);
        check("ignore_rk_last_a", rk_last_a, 128'hac7766f319fadc2128d12941575c006e);
        check("ignore_rk_last_b", rk_last_b, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_check("ignore_rk0", 4'd0, FIPS_KEY);

        // Reset mid-expansion
        key_in    = 128'h0;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mid_busy_before_rst", 128'(busy), 128'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_key_ready", 128'(key_ready), 128'd1);
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_done", 128'(done), 128'd0);
        check("mid_rst_keys_valid", 128'(keys_valid), 128'd0);
        check("mid_rst_rk_last_a", rk_last_a, 128'h0);
        check("mid_rst_rk_last_b", rk_last_b, 128'h0);
        read_check("mid_rst_rk1", 4'd1, 128'h0);
        tick();
        rst = 1'b0;
        tick();
        expand(FIPS_KEY);
        check("post_rst_rk_last_b", rk_last_b, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Re-key from DONE with the zero key
        expand(128'h0);
        check("rekey_rk_last_b", rk_last_b, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Back-to-back with key_valid held
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        key_in    = ka;
        key_valid = 1'b1;
        tick();
        cnt = 0;
        while (!keys_valid && cnt < 30) begin
            tick();
            cnt++;
        end
        check("b2b_latency_a", 128'(cnt), 128'd10);
        check("b2b_done_a", 128'(done), 128'd1);
        check("b2b_rk_last_b_a", rk_last_b, model_rk(ka, 10));
        key_in = kb;
        tick();
        check("b2b_busy_b", 128'(busy), 128'd1);
        check("b2b_kv_drop", 128'(keys_valid), 128'd0);
        check("b2b_done_clear", 128'(done), 128'd0);
        key_valid = 1'b0;
        cnt = 0;
        dn  = 0;
        while (!keys_valid && cnt < 30) begin
            tick();
            cnt++;
            if (done) dn++;
        end
        check("b2b_latency_b", 128'(cnt), 128'd10);
        check("b2b_done_b", 128'(dn), 128'd1);
        for (int r = 0; r <= 10; r++) read_check($sformatf("b2b_rk%0d", r), 4'(r), model_rk(kb, r));

        // Random keys against the model
        for (int n = 0; n < 6; n++) begin
            ka = {$urandom, $urandom, $urandom, $urandom};
            expand(ka);
            for (int r = 0; r <= 15; r++) begin
                read_check($sformatf("rand%0d_rk%0d", n, r), 4'(r), model_rk(ka, r));
            end
            check("rand_rk_last_a", rk_last_a, model_rk(ka, 9));
            check("rand_rk_last_b", rk_last_b, model_rk(ka, 10));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
